// File: rtl/memshare_wb_addr_ctrl_if.sv
`default_nettype none
// ============================================================================
// memshare_wb_addr_ctrl_if : SCU write handshake and message-buffer write port
// Revision: 1.0
// ============================================================================
interface memshare_wb_addr_ctrl_if #(
    parameter int MSGPASS_BUFF_ADDR_WIDTH = 6,
    parameter int MSG_WIDTH               = 16,
    parameter int MEMSHARE_DRC_NUM        = 2
);
    logic                               wr_valid_i;
    logic                               wr_ready_o;
    logic [MSG_WIDTH-1:0]               wr_data_i;
    logic [MEMSHARE_DRC_NUM-1:0]        is_drc_i;
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] drc_stride_i;
    logic                               msgPass_we_o;
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0] msgPass_waddr_o;
    logic [MSG_WIDTH-1:0]               msgPass_wdata_o;

    // SCU side: presents messages, observes the buffer write port
    modport master (
        output wr_valid_i, wr_data_i, is_drc_i, drc_stride_i,
        input  wr_ready_o, msgPass_we_o, msgPass_waddr_o, msgPass_wdata_o
    );

    // Controller side
    modport slave (
        input  wr_valid_i, wr_data_i, is_drc_i, drc_stride_i,
        output wr_ready_o, msgPass_we_o, msgPass_waddr_o, msgPass_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/memshare_wb_addr_ctrl.sv
`default_nettype none
// ============================================================================
// memshare_wb_addr_ctrl : write-back address controller for SCU.memShare()
// Revision: 1.0
// ============================================================================
module memshare_wb_addr_ctrl #(
    parameter int MSGPASS_BUFF_ADDR_WIDTH = 6,
    parameter int MSG_WIDTH               = 16,
    parameter int MEMSHARE_DRC_NUM        = 2,
    parameter int MEMSHARE_DRC1           = 1,
    parameter int MSGPASS_ADDR_BASE       = 0,
    parameter int ADDR_DEPTH              = 48,
    parameter int CNT_WIDTH               = $clog2(ADDR_DEPTH+1)
) (
    input  wire logic                 sys_clk,
    input  wire logic                 rstn,
    input  wire logic                 scu_begin_i,
    input  wire logic                 scu_end_i,
    memshare_wb_addr_ctrl_if.slave    wr_if,
    output logic                      wb_done_o,
    output logic [CNT_WIDTH-1:0]      wb_count_o,
    output logic                      wb_ovf_o
);
    localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
    localparam int LIMIT_INT = MSGPASS_ADDR_BASE + ADDR_DEPTH;
    localparam logic [AW:0]          LIMIT     = (AW+1)'(LIMIT_INT);
    localparam logic [AW:0]          DEPTH_EXT = (AW+1)'(ADDR_DEPTH);
    localparam logic [AW-1:0]        BASE_ADDR = AW'(MSGPASS_ADDR_BASE);
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(ADDR_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   we_q, we_d;
    logic [AW-1:0]          waddr_q, waddr_d;
    logic [MSG_WIDTH-1:0]   wdata_q, wdata_d;

    logic                   accept;
    logic [AW-1:0]          step;
    logic [AW:0]            sum;
    logic [AW-1:0]          ptr_next;
    logic                   drc_unused;

    // Only the DRC1 flag steers the pointer; other flags are don't-care here
    assign drc_unused = ^wr_if.is_drc_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        // A restart in the same cycle wins over any presented write
        accept   = ready_q && wr_if.wr_valid_i && !scu_begin_i;
        step     = wr_if.is_drc_i[MEMSHARE_DRC1] ? wr_if.drc_stride_i : AW'(1);
        sum      = {1'b0, ptr_q} + {1'b0, step};
        ptr_next = (sum >= LIMIT) ? AW'(sum - DEPTH_EXT) : sum[AW-1:0];
        we_d     = accept;

        if (accept) begin
            waddr_d = ptr_q;
            wdata_d = wr_if.wr_data_i;
            ptr_d   = ptr_next;
            if (count_q == DEPTH_CNT) begin
                ovf_d = 1'b1;
            end
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end

        case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_ACTIVE: if (scu_end_i) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (scu_begin_i) begin
            state_d = ST_ACTIVE;
            ptr_d   = BASE_ADDR;
            count_d = '0;
            ovf_d   = 1'b0;
        end

        ready_d = (state_d == ST_ACTIVE);
        done_d  = (state_d == ST_DRAIN);
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= BASE_ADDR;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wr_if.wr_ready_o      = ready_q;
    assign wr_if.msgPass_we_o    = we_q;
    assign wr_if.msgPass_waddr_o = waddr_q;
    assign wr_if.msgPass_wdata_o = wdata_q;
    assign wb_done_o             = done_q;
    assign wb_count_o            = count_q;
    assign wb_ovf_o              = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_memshare_wb_addr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_memshare_wb_addr_ctrl : directed + random bench with a reference model
// Revision: 1.0
// ============================================================================
module tb_memshare_wb_addr_ctrl;
    localparam int AW    = 6;
    localparam int MW    = 16;
    localparam int DRCN  = 2;
    localparam int DEPTH = 48;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int CMAX  = (1 << CW) - 1;

    logic          sys_clk = 1'b0;
    logic          rstn;
    logic          scu_begin;
    logic          scu_end;
    logic          wb_done;
    logic [CW-1:0] wb_count;
    logic          wb_ovf;

    memshare_wb_addr_ctrl_if #(
        .MSGPASS_BUFF_ADDR_WIDTH(AW),
        .MSG_WIDTH(MW),
        .MEMSHARE_DRC_NUM(DRCN)
    ) bus ();

    memshare_wb_addr_ctrl dut (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .scu_begin_i (scu_begin),
        .scu_end_i   (scu_end),
        .wr_if       (bus),
        .wb_done_o   (wb_done),
        .wb_count_o  (wb_count),
        .wb_ovf_o    (wb_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: period framing and pointer arithmetic in plain integers
    bit m_active;
    int m_ptr;
    int m_count;
    bit m_ovf;
    bit e_we;
    int e_addr;
    int e_data;
    bit e_ready;
    bit e_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("we", 32'(bus.msgPass_we_o), 32'(e_we));
        if (e_we) begin
            check("waddr", 32'(bus.msgPass_waddr_o), 32'(e_addr));
            check("wdata", 32'(bus.msgPass_wdata_o), 32'(e_data));
        end
        check("ready", 32'(bus.wr_ready_o), 32'(e_ready));
        check("done", 32'(wb_done), 32'(e_done));
        check("count", 32'(wb_count), 32'(m_count));
        check("ovf", 32'(wb_ovf), 32'(m_ovf));
    endtask

    task automatic step(input bit b, input bit e, input bit v, input logic [MW-1:0] d,
                        input logic [DRCN-1:0] drc, input logic [AW-1:0] stride);
        int stp;
        @(negedge sys_clk);
        scu_begin        = b;
        scu_end          = e;
        bus.wr_valid_i   = v;
        bus.wr_data_i    = d;
        bus.is_drc_i     = drc;
        bus.drc_stride_i = stride;

        stp  = drc[1] ? int'(stride) : 1;
        e_we = m_active && v && !b;
        if (e_we) begin
            e_addr = m_ptr;
            e_data = int'(d);
            if (m_count == DEPTH) m_ovf = 1'b1;
            if (m_count < CMAX) m_count++;
            m_ptr = (m_ptr + stp >= DEPTH) ? m_ptr + stp - DEPTH : m_ptr + stp;
        end
        e_done = !b && m_active && e;
        if (b) begin
            m_active = 1'b1;
            m_ptr    = 0;
            m_count  = 0;
            m_ovf    = 1'b0;
        end else if (m_active && e) begin
            m_active = 1'b0;
        end
        e_ready = m_active;

        @(posedge sys_clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 6'd0);
    endtask

    task automatic wr(input logic [MW-1:0] d);
        step(1'b0, 1'b0, 1'b1, d, 2'b00, 6'd0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rstn           = 1'b0;
        bus.wr_valid_i = 1'b1;
        @(posedge sys_clk);
        #1;
        m_active = 1'b0;
        m_ptr    = 0;
        m_count  = 0;
        m_ovf    = 1'b0;
        e_we     = 1'b0;
        e_ready  = 1'b0;
        e_done   = 1'b0;
        check_outputs();
        check("rst_waddr", 32'(bus.msgPass_waddr_o), 32'd0);
        check("rst_wdata", 32'(bus.msgPass_wdata_o), 32'd0);
        @(negedge sys_clk);
        rstn           = 1'b1;
        bus.wr_valid_i = 1'b0;
    endtask

    initial begin
        rstn             = 1'b0;
        scu_begin        = 1'b0;
        scu_end          = 1'b0;
        bus.wr_valid_i   = 1'b0;
        bus.wr_data_i    = '0;
        bus.is_drc_i     = '0;
        bus.drc_stride_i = '0;

        do_reset();

        // Writes offered while idle are ignored
        step(1'b0, 1'b0, 1'b1, 16'h1234, 2'b00, 6'd0);
        step(1'b0, 1'b1, 1'b1, 16'h5678, 2'b10, 6'd4);

        // Basic stream 0xA0..0xA3
        step(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 6'd0);
        for (int i = 0; i < 4; i++) wr(16'(16'hA0 + i));
        step(1'b0, 1'b1, 1'b0, 16'h0, 2'b00, 6'd0);
        check("basic_count", 32'(wb_count), 32'd4);
        idle();
        idle();

        // DRC stride on the second accept only
        step(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 6'd5);
        step(1'b0, 1'b0, 1'b1, 16'hB0, 2'b00, 6'd5);
        step(1'b0, 1'b0, 1'b1, 16'hB1, 2'b10, 6'd5);
        step(1'b0, 1'b0, 1'b1, 16'hB2, 2'b00, 6'd5);
        step(1'b0, 1'b0, 1'b1, 16'hB3, 2'b01, 6'd5);
        check("drc_addr", 32'(bus.msgPass_waddr_o), 32'd7);
        // End coincident with an accept: final write and done share a cycle
        step(1'b0, 1'b1, 1'b1, 16'hB4, 2'b00, 6'd5);
        check("end_we", 32'(bus.msgPass_we_o), 32'd1);
        check("end_done", 32'(wb_done), 32'd1);
        idle();

        // Wrap at 46 + 3, overflow on the 49th accept, saturation beyond
        step(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 6'd0);
        for (int i = 0; i < 46; i++) wr(16'($urandom_range(0, 16'hFFFF)));
        step(1'b0, 1'b0, 1'b1, 16'hC0DE, 2'b10, 6'd3);
        wr(16'hC1);
        check("wrap_addr", 32'(bus.msgPass_waddr_o), 32'd1);
        wr(16'hC2);
        check("ovf_set", 32'(wb_ovf), 32'd1);
        check("ovf_we", 32'(bus.msgPass_we_o), 32'd1);
        for (int i = 0; i < 16; i++) wr(16'($urandom_range(0, 16'hFFFF)));
        check("count_sat", 32'(wb_count), 32'(CMAX));

        // Restart while active: presented write dropped, state cleared
        step(1'b1, 1'b0, 1'b1, 16'hDEAD, 2'b00, 6'd0);
        check("restart_ovf", 32'(wb_ovf), 32'd0);
        // Gaps: valid 1, 0, 1
        wr(16'hD0);
        idle();
        wr(16'hD1);
        check("gap_addr", 32'(bus.msgPass_waddr_o), 32'd1);
        step(1'b0, 1'b1, 1'b0, 16'h0, 2'b00, 6'd0);
        idle();

        // Reset mid-stream after 3 writes, then restart at address 0
        step(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 6'd0);
        for (int i = 0; i < 3; i++) wr(16'(16'hE0 + i));
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 6'd0);
        wr(16'hF0);
        check("restart_addr", 32'(bus.msgPass_waddr_o), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0,
                 16'($urandom_range(0, 16'hFFFF)),
                 2'($urandom_range(0, 3)),
                 6'($urandom_range(0, DEPTH - 1)));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
